// File: rtl/pong_core.sv
`default_nettype none
// ============================================================================
// Module      : pong_core
// Description : Per-frame Pong engine and pixel renderer. Game state advances
//               once per frame on the rising edge of vertical blank; the rest
//               of the frame renders that state to 3-bit RGB.
//               Optional macro PONG_AUTOPADDLE_EN: right paddle tracks the ball.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_core #(
    parameter int HRES         = 640,
    parameter int VRES         = 480,
    parameter int PAD_W        = 8,
    parameter int PAD_H        = 64,
    parameter int PAD_XL       = 16,
    parameter int PAD_XR       = 616,
    parameter int BALL_SZ      = 8,
    parameter int BALL_SPD     = 2,
    parameter int PAD_SPD      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_x,
    input  logic [11:0] i_y,
    input  logic        i_hblank,
    input  logic        i_vblank,
    input  logic        i_up_l,
    input  logic        i_dn_l,
    input  logic        i_up_r,
    input  logic        i_dn_r,
    input  logic        i_start,
    output logic        o_red,
    output logic        o_grn,
    output logic        o_blu,
    output logic [3:0]  o_score_l,
    output logic [3:0]  o_score_r,
    output logic [1:0]  o_state
);

    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

    localparam logic signed [11:0] C_BALL_X0   = 12'(HRES / 2 - BALL_SZ / 2);
    localparam logic signed [11:0] C_BALL_Y0   = 12'(VRES / 2 - BALL_SZ / 2);
    localparam logic signed [11:0] C_PAD_Y0    = 12'((VRES - PAD_H) / 2);
    localparam logic signed [11:0] C_PAD_YMAX  = 12'(VRES - PAD_H);
    localparam logic signed [11:0] C_BALL_YMAX = 12'(VRES - BALL_SZ);
    localparam logic signed [11:0] C_BALL_XMAX = 12'(HRES - BALL_SZ);
    localparam logic signed [11:0] C_HIT_L     = 12'(PAD_XL + PAD_W);
    localparam logic signed [11:0] C_HIT_R     = 12'(PAD_XR - BALL_SZ);
    localparam logic signed [11:0] C_BSPD      = 12'(BALL_SPD);
    localparam logic signed [11:0] C_PSPD      = 12'(PAD_SPD);
    localparam logic signed [11:0] C_PAD_H     = 12'(PAD_H);
    localparam logic signed [11:0] C_BALL_SZ   = 12'(BALL_SZ);
    localparam logic signed [12:0] C_PXL_LO    = 13'(PAD_XL);
    localparam logic signed [12:0] C_PXL_HI    = 13'(PAD_XL + PAD_W);
    localparam logic signed [12:0] C_PXR_LO    = 13'(PAD_XR);
    localparam logic signed [12:0] C_PXR_HI    = 13'(PAD_XR + PAD_W);
    localparam logic [11:0]        C_MID       = 12'(HRES / 2);
    localparam logic [3:0]         C_WIN       = 4'(WIN_SCORE);

    logic [1:0]         r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [3:0]         r_score_l, r_score_r, w_score_l_nx, w_score_r_nx, w_sc;
    logic signed [11:0] r_bx, r_by, r_vx, r_vy, r_pyl, r_pyr;
    logic signed [11:0] w_bx_nx, w_by_nx, w_vx_nx, w_vy_nx, w_pyl_nx, w_pyr_nx;
    logic signed [11:0] w_nx, w_ny, w_by_new, w_vy_new, w_pyl_step, w_pyr_step;
    logic               w_ovl_l, w_ovl_r, w_pt_l, w_pt_r;
    logic               r_vblank_d, w_tick;
    logic [2:0]         r_rgb, w_rgb;
    logic signed [12:0] w_sx, w_sy;
    logic               w_in_ball, w_in_pl, w_in_pr, w_mid;

    function automatic logic signed [11:0] f_pad_step(
        input logic signed [11:0] py,
        input logic               up,
        input logic               dn
    );
        logic signed [11:0] v;
        v = py;
        if (up && !dn)
            v = (py < C_PSPD) ? 12'sd0 : py - C_PSPD;
        else if (dn && !up)
            v = (py + C_PSPD > C_PAD_YMAX) ? C_PAD_YMAX : py + C_PSPD;
        return v;
    endfunction

    assign w_tick     = i_vblank & ~r_vblank_d;
    assign w_pyl_step = f_pad_step(r_pyl, i_up_l, i_dn_l);

`ifdef PONG_AUTOPADDLE_EN
    logic signed [11:0] w_diff;
    logic               w_unused_btn;
    assign w_diff       = (r_by + 12'(BALL_SZ / 2)) - (r_pyr + 12'(PAD_H / 2));
    assign w_pyr_step   = f_pad_step(r_pyr, w_diff < -C_PSPD, w_diff > C_PSPD);
    assign w_unused_btn = i_up_r ^ i_dn_r;
`else
    assign w_pyr_step = f_pad_step(r_pyr, i_up_r, i_dn_r);
`endif

    // Next-state and game datapath
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_score_l_nx = r_score_l;
        w_score_r_nx = r_score_r;
        w_bx_nx      = r_bx;
        w_by_nx      = r_by;
        w_vx_nx      = r_vx;
        w_vy_nx      = r_vy;
        w_pyl_nx     = r_pyl;
        w_pyr_nx     = r_pyr;
        w_pt_l       = 1'b0;
        w_pt_r       = 1'b0;
        w_sc         = 4'd0;

        w_nx     = r_bx + r_vx;
        w_ny     = r_by + r_vy;
        w_by_new = w_ny;
        w_vy_new = r_vy;
        if (w_ny <= 12'sd0) begin
            w_by_new = 12'sd0;
            w_vy_new = C_BSPD;
        end else if (w_ny >= C_BALL_YMAX) begin
            w_by_new = C_BALL_YMAX;
            w_vy_new = -C_BSPD;
        end
        // Overlap uses the already-bounced row and the pre-tick paddles
        w_ovl_l = (w_by_new + C_BALL_SZ > r_pyl) && (w_by_new < r_pyl + C_PAD_H);
        w_ovl_r = (w_by_new + C_BALL_SZ > r_pyr) && (w_by_new < r_pyr + C_PAD_H);

        if (r_state == S_OVER && i_start) begin
            w_state_nx   = S_SERVE;
            w_cnt_nx     = '0;
            w_score_l_nx = 4'd0;
            w_score_r_nx = 4'd0;
            w_bx_nx      = C_BALL_X0;
            w_by_nx      = C_BALL_Y0;
            w_pyl_nx     = C_PAD_Y0;
            w_pyr_nx     = C_PAD_Y0;
        end else if (w_tick) begin
            w_pyl_nx = w_pyl_step;
            w_pyr_nx = w_pyr_step;
            case (r_state)
                S_SERVE: begin
                    w_bx_nx = C_BALL_X0;
                    w_by_nx = C_BALL_Y0;
                    if (r_cnt == C_CNT_LAST) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_PLAY;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    w_by_nx = w_by_new;
                    w_vy_nx = w_vy_new;
                    if (r_vx < 12'sd0) begin
                        if (w_nx <= C_HIT_L && w_ovl_l) begin
                            w_bx_nx = C_HIT_L;
                            w_vx_nx = C_BSPD;
                        end else if (w_nx <= 12'sd0) begin
                            w_pt_r = 1'b1;
                        end else begin
                            w_bx_nx = w_nx;
                        end
                    end else begin
                        if (w_nx >= C_HIT_R && w_ovl_r) begin
                            w_bx_nx = C_HIT_R;
                            w_vx_nx = -C_BSPD;
                        end else if (w_nx >= C_BALL_XMAX) begin
                            w_pt_l = 1'b1;
                        end else begin
                            w_bx_nx = w_nx;
                        end
                    end
                    // A point recentres the ball and serves toward the conceder
                    if (w_pt_l || w_pt_r) begin
                        w_bx_nx = C_BALL_X0;
                        w_by_nx = C_BALL_Y0;
                        if (w_pt_l) begin
                            w_sc         = (r_score_l == C_WIN) ? r_score_l : r_score_l + 4'd1;
                            w_score_l_nx = w_sc;
                            w_vx_nx      = C_BSPD;
                        end else begin
                            w_sc         = (r_score_r == C_WIN) ? r_score_r : r_score_r + 4'd1;
                            w_score_r_nx = w_sc;
                            w_vx_nx      = -C_BSPD;
                        end
                        w_state_nx = (w_sc == C_WIN) ? S_OVER : S_SERVE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel renderer; x/y widened so they never alias negative positions
    always_comb begin
        w_sx      = $signed({1'b0, i_x});
        w_sy      = $signed({1'b0, i_y});
        w_in_ball = (w_sx >= 13'(r_bx)) && (w_sx < 13'(r_bx + C_BALL_SZ)) &&
                    (w_sy >= 13'(r_by)) && (w_sy < 13'(r_by + C_BALL_SZ));
        w_in_pl   = (w_sx >= C_PXL_LO) && (w_sx < C_PXL_HI) &&
                    (w_sy >= 13'(r_pyl)) && (w_sy < 13'(r_pyl + C_PAD_H));
        w_in_pr   = (w_sx >= C_PXR_LO) && (w_sx < C_PXR_HI) &&
                    (w_sy >= 13'(r_pyr)) && (w_sy < 13'(r_pyr + C_PAD_H));
        w_mid     = ((i_x == C_MID - 12'd1) || (i_x == C_MID)) && !i_y[4];
        w_rgb     = 3'b000;
        if (i_hblank || i_vblank)
            w_rgb = 3'b000;
        else if (w_in_ball)
            w_rgb = 3'b111;
        else if (w_in_pl)
            w_rgb = (r_state == S_OVER && r_score_l == C_WIN) ? 3'b100 : 3'b111;
        else if (w_in_pr)
            w_rgb = (r_state == S_OVER && r_score_r == C_WIN) ? 3'b100 : 3'b111;
        else if (w_mid)
            w_rgb = 3'b001;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_SERVE;
            r_cnt      <= '0;
            r_score_l  <= 4'd0;
            r_score_r  <= 4'd0;
            r_bx       <= C_BALL_X0;
            r_by       <= C_BALL_Y0;
            r_vx       <= C_BSPD;
            r_vy       <= C_BSPD;
            r_pyl      <= C_PAD_Y0;
            r_pyr      <= C_PAD_Y0;
            r_vblank_d <= 1'b1;
            r_rgb      <= 3'b000;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_score_l  <= w_score_l_nx;
            r_score_r  <= w_score_r_nx;
            r_bx       <= w_bx_nx;
            r_by       <= w_by_nx;
            r_vx       <= w_vx_nx;
            r_vy       <= w_vy_nx;
            r_pyl      <= w_pyl_nx;
            r_pyr      <= w_pyr_nx;
            r_vblank_d <= i_vblank;
            r_rgb      <= w_rgb;
        end
    end

    assign {o_red, o_grn, o_blu} = r_rgb;
    assign o_score_l = r_score_l;
    assign o_score_r = r_score_r;
    assign o_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pong_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_core
// Description : Directed bench for pong_core with a frame-level game model and
//               an RGB scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_core;

    logic        clk = 1'b0;
    logic        rst, hblank, vblank, up_l, dn_l, up_r, dn_r, start;
    logic [11:0] x, y;
    logic        red, grn, blu;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [2:0]  q_exp[$];

    int m_state, m_cnt, m_sl, m_sr, m_bx, m_by, m_vx, m_vy, m_pyl, m_pyr;

    pong_core dut (
        .i_clk(clk), .i_rst(rst), .i_x(x), .i_y(y),
        .i_hblank(hblank), .i_vblank(vblank),
        .i_up_l(up_l), .i_dn_l(dn_l), .i_up_r(up_r), .i_dn_r(dn_r),
        .i_start(start),
        .o_red(red), .o_grn(grn), .o_blu(blu),
        .o_score_l(score_l), .o_score_r(score_r), .o_state(state)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [2:0] e;
        @(posedge clk);
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_checks++;
            assert ({red, grn, blu} === e) else begin
                n_errors++;
                $error("FAIL rgb observed %b expected %b", {red, grn, blu}, e);
            end
        end
    endtask

    task automatic pix(input int px, input int py, input logic hb, input logic vb,
                       input logic [2:0] e);
        x      = 12'(px);
        y      = 12'(py);
        hblank = hb;
        vblank = vb;
        q_exp.push_back(e);
        step();
    endtask

    function automatic int m_pad(input int py, input logic u, input logic d);
        if (u && !d) return (py - 4 < 0) ? 0 : py - 4;
        if (d && !u) return (py + 4 > 416) ? 416 : py + 4;
        return py;
    endfunction

    function automatic logic [2:0] m_rgb(input int px, input int py, input logic hb,
                                         input logic vb);
        if (hb || vb) return 3'b000;
        if (px >= m_bx && px < m_bx + 8 && py >= m_by && py < m_by + 8) return 3'b111;
        if (px >= 16 && px < 24 && py >= m_pyl && py < m_pyl + 64)
            return (m_state == 2 && m_sl == 9) ? 3'b100 : 3'b111;
        if (px >= 616 && px < 624 && py >= m_pyr && py < m_pyr + 64)
            return (m_state == 2 && m_sr == 9) ? 3'b100 : 3'b111;
        if ((px == 319 || px == 320) && ((py >> 4) & 1) == 0) return 3'b001;
        return 3'b000;
    endfunction

    task automatic m_tick(input logic ul, input logic dl, input logic ur, input logic dr);
        int opyl, opyr, nx, ny;
        logic pl, pr;
        opyl  = m_pyl;
        opyr  = m_pyr;
        m_pyl = m_pad(m_pyl, ul, dl);
        m_pyr = m_pad(m_pyr, ur, dr);
        pl = 1'b0;
        pr = 1'b0;
        if (m_state == 0) begin
            m_bx = 316;
            m_by = 236;
            m_cnt++;
            if (m_cnt == 60) begin
                m_cnt   = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            nx = m_bx + m_vx;
            ny = m_by + m_vy;
            if (ny <= 0) begin m_by = 0; m_vy = 2; end
            else if (ny >= 472) begin m_by = 472; m_vy = -2; end
            else m_by = ny;
            if (m_vx < 0) begin
                if (nx <= 24 && m_by + 8 > opyl && m_by < opyl + 64) begin m_bx = 24; m_vx = 2; end
                else if (nx <= 0) pr = 1'b1;
                else m_bx = nx;
            end else begin
                if (nx >= 608 && m_by + 8 > opyr && m_by < opyr + 64) begin m_bx = 608; m_vx = -2; end
                else if (nx >= 632) pl = 1'b1;
                else m_bx = nx;
            end
            if (pl) begin m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_vx = 2; end
            if (pr) begin m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_vx = -2; end
            if (pl || pr) begin
                m_bx    = 316;
                m_by    = 236;
                m_state = (m_sl == 9 || m_sr == 9) ? 2 : 0;
            end
        end
    endtask

    // One short frame: three rendered pixels, the tick cycle, one blank cycle
    task automatic frame(input logic ul, input logic dl, input logic ur, input logic dr,
                         input logic st);
        int was_vx;
        pix(m_bx + 4, m_by + 4, 1'b0, 1'b0, m_rgb(m_bx + 4, m_by + 4, 1'b0, 1'b0));
        pix(20, m_pyl + 32, 1'b0, 1'b0, m_rgb(20, m_pyl + 32, 1'b0, 1'b0));
        pix(620, m_pyr + 32, 1'b0, 1'b0, m_rgb(620, m_pyr + 32, 1'b0, 1'b0));
        up_l  = ul;
        dn_l  = dl;
        up_r  = ur;
        dn_r  = dr;
        start = st;
        pix(320, 240, 1'b0, 1'b1, 3'b000);
        start  = 1'b0;
        was_vx = m_vx;
        if (st && m_state == 2) begin
            m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0;
            m_bx = 316; m_by = 236; m_pyl = 208; m_pyr = 208;
        end else begin
            m_tick(ul, dl, ur, dr);
        end
        chk("state", int'(state), m_state);
        chk("score_l", int'(score_l), m_sl);
        chk("score_r", int'(score_r), m_sr);
        chk("bx", int'(dut.r_bx), m_bx);
        chk("by", int'(dut.r_by), m_by);
        chk("vx", int'(dut.r_vx), m_vx);
        chk("vy", int'(dut.r_vy), m_vy);
        chk("pyl", int'(dut.r_pyl), m_pyl);
        chk("pyr", int'(dut.r_pyr), m_pyr);
        if (was_vx < 0 && m_vx > 0 && m_state == 1) chk("lhit_bx", int'(dut.r_bx), 24);
        if (m_state == 1 && m_by == 0) chk("top_vy", int'(dut.r_vy), 2);
        pix(320, 240, 1'b1, 1'b1, 3'b000);
    endtask

    initial begin
        rst = 1'b1; hblank = 1'b0; vblank = 1'b0; start = 1'b0;
        up_l = 1'b0; dn_l = 1'b0; up_r = 1'b0; dn_r = 1'b0;
        x = 12'd320; y = 12'd240;
        m_state = 0; m_cnt = 0; m_sl = 0; m_sr = 0;
        m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2; m_pyl = 208; m_pyr = 208;

        pix(320, 240, 1'b0, 1'b0, 3'b000);
        pix(320, 240, 1'b0, 1'b0, 3'b000);
        rst = 1'b0;
        pix(320, 240, 1'b0, 1'b0, 3'b111);
        chk("rst_state", int'(state), 0);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_score_r", int'(score_r), 0);
        chk("rst_pyl", int'(dut.r_pyl), 208);
        chk("rst_pyr", int'(dut.r_pyr), 208);
        chk("rst_bx", int'(dut.r_bx), 316);
        chk("rst_by", int'(dut.r_by), 236);

        // Static render probes at reset positions, including area edges
        pix(319, 0, 1'b0, 1'b0, 3'b001);
        pix(320, 15, 1'b0, 1'b0, 3'b001);
        pix(319, 16, 1'b0, 1'b0, 3'b000);
        pix(20, 240, 1'b0, 1'b0, 3'b111);
        pix(24, 240, 1'b0, 1'b0, 3'b000);
        pix(620, 271, 1'b0, 1'b0, 3'b111);
        pix(620, 272, 1'b0, 1'b0, 3'b000);
        pix(316, 236, 1'b0, 1'b0, 3'b111);
        pix(324, 236, 1'b0, 1'b0, 3'b000);
        pix(320, 240, 1'b1, 1'b0, 3'b000);

        // Serve timer
        for (int f = 0; f < 61; f++) begin
            frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (f == 59) chk("serve_to_play", int'(state), 1);
            if (f == 60) begin
                chk("first_bx", int'(dut.r_bx), 318);
                chk("first_by", int'(dut.r_by), 238);
            end
        end

        // Right tracks the ball, left dodges it: right player scores once
        for (int f = 0; f < 2000 && m_sr == 0; f++) begin
            int bc, lc, rc;
            bc = m_by + 4; lc = m_pyl + 32; rc = m_pyr + 32;
            frame(bc >= lc, bc < lc, bc < rc - 4, bc > rc + 4, 1'b0);
        end
        chk("miss_score_r", int'(score_r), 1);
        chk("miss_state", int'(state), 0);
        chk("miss_bx", int'(dut.r_bx), 316);
        chk("miss_by", int'(dut.r_by), 236);
        chk("miss_vx", int'(dut.r_vx), -2);

        // Left tracks, right dodges: left player runs to the winning score
        for (int f = 0; f < 4000 && m_state != 2; f++) begin
            int bc, lc, rc;
            bc = m_by + 4; lc = m_pyl + 32; rc = m_pyr + 32;
            frame(bc < lc - 4, bc > lc + 4, bc >= rc, bc < rc, 1'b0);
        end
        chk("over_state", int'(state), 2);
        chk("over_score_l", int'(score_l), 9);
        pix(20, m_pyl + 32, 1'b0, 1'b0, 3'b100);
        pix(620, m_pyr + 32, 1'b0, 1'b0, 3'b111);

        // Restart coinciding with a tick, buttons held: no motion that frame
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rs_score_l", int'(score_l), 0);
        chk("rs_score_r", int'(score_r), 0);
        chk("rs_state", int'(state), 0);
        chk("rs_pyl", int'(dut.r_pyl), 208);
        chk("rs_pyr", int'(dut.r_pyr), 208);
        chk("rs_bx", int'(dut.r_bx), 316);
        frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post_pyl", int'(dut.r_pyl), 204);
        chk("post_pyr", int'(dut.r_pyr), 212);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_core.md
# pong_core

Per-frame Pong game engine and pixel renderer. It consumes the visible-pixel coordinates and blanking flags from the VGA timing stage and produces the 3-bit RGB drive for the connector pins. Once per frame it advances the game state: paddles, ball, collisions, scores and the serve/game-over sequence. The rest of each frame is spent rendering that state pixel by pixel.

## Interface
Parameters:
- HRES, 640, visible width in pixels
- VRES, 480, visible height in lines
- PAD_W, 8, paddle width
- PAD_H, 64, paddle height
- PAD_XL, 16, left paddle left edge
- PAD_XR, 616, right paddle left edge
- BALL_SZ, 8, ball edge length (square)
- BALL_SPD, 2, ball step per frame on each axis
- PAD_SPD, 4, paddle step per frame
- WIN_SCORE, 9, score that ends the game
- SERVE_FRAMES, 60, frames of pause before a serve

Ports:
- i_clk  in  1  pixel clock (25 MHz); the only clock
- i_rst  in  1  synchronous, active-high reset
- i_x  in  12  visible column 0..HRES-1; don't-care while blanked
- i_y  in  12  visible line 0..VRES-1; don't-care while blanked
- i_hblank  in  1  horizontal blank
- i_vblank  in  1  vertical blank
- i_up_l, i_dn_l, i_up_r, i_dn_r  in  1 each  paddle buttons, pre-synchronised, level
- i_start  in  1  restart request, level, sampled each cycle
- o_red, o_grn, o_blu  out  1 each  pixel colour, registered
- o_score_l, o_score_r  out  4 each  current scores
- o_state  out  2  0 = SERVE, 1 = PLAY, 2 = OVER

## Operation
- Frame tick: single-cycle pulse on the rising edge of i_vblank, detected from a registered copy of i_vblank. All game updates happen only on a tick cycle.
- Arithmetic: ball and paddle positions are held in signed 12-bit registers. Velocities are ±BALL_SPD. Candidate position nx = bx + vx, ny = by + vy.
- Paddle update on every tick, in all states:
  - up and not down: py = max(0, py − PAD_SPD).
  - down and not up: py = min(VRES − PAD_H, py + PAD_SPD).
  - both or neither: hold.
- SERVE:
  - Ball is held at the centre, (HRES/2 − BALL_SZ/2, VRES/2 − BALL_SZ/2) = (316, 236).
  - A frame counter increments on each tick. When it reaches SERVE_FRAMES, the counter is cleared and the block enters PLAY.
- PLAY, per tick:
  1. Vertical: if ny ≤ 0, set by = 0 and vy = +BALL_SPD. If ny ≥ VRES − BALL_SZ, set by = VRES − BALL_SZ and vy = −BALL_SPD. Otherwise by = ny.
  2. Left side (vx < 0):
     - Hit: nx ≤ PAD_XL + PAD_W and vertical overlap (by + BALL_SZ > pyl and by < pyl + PAD_H). Set bx = PAD_XL + PAD_W and vx = +BALL_SPD.
     - Miss: no hit and nx ≤ 0. Right player scores.
     - Otherwise bx = nx.
  3. Right side (vx > 0): mirror of the left side, using PAD_XR − BALL_SZ and the limit HRES − BALL_SZ. A miss means the left player scores.
  4. Overlap is tested against the paddle position from before this tick.
- Scoring:
  - The scorer's count increments.
  - If the new count equals WIN_SCORE, go to OVER.
  - Otherwise go to SERVE. vx is set to point toward the player who conceded; vy keeps its sign.
  - Scores saturate at WIN_SCORE.
- OVER:
  - The ball is frozen; paddles still move.
  - i_start high, on any cycle, clears both scores, centres the ball and paddles, and enters SERVE.
  - If i_start coincides with a tick, the restart wins and no motion is applied that frame.
- Render, evaluated every cycle from i_x/i_y and the current registers:
  - Blanked (i_hblank or i_vblank): 000.
  - Else ball area: 111.
  - Else paddle area: 111, except the winner's paddle in OVER, which is 100.
  - Else centre line (i_x in HRES/2−1..HRES/2 and i_y[4] == 0): 001.
  - Else 000.
  - Priority is in that order: ball > paddles > centre line.
- Reset values:
  - State SERVE, serve counter 0, scores 0.
  - Ball (316, 236), vx = +BALL_SPD, vy = +BALL_SPD.
  - Both paddles at (VRES − PAD_H)/2 = 208.
  - RGB outputs 000, previous-vblank register 1 (so no tick is generated in the cycle after reset).

## Timing
- RGB latency: exactly 1 cycle from i_x/i_y/blanking to o_red/o_grn/o_blu.
- Game-state registers, o_score_* and o_state update on the tick cycle and are visible the cycle after it.
- Since the tick falls at the start of vertical blank, every visible frame renders one constant state.
- Reset asserted mid-line: RGB is 000 the following cycle, and state is at reset values that cycle.
- At most one point can be scored per tick. Vertical and horizontal bounces in the same tick are both applied.

## Configuration
- Macro: PONG_AUTOPADDLE_EN.
- Defined: the right paddle ignores i_up_r/i_dn_r. On each tick it steps PAD_SPD toward aligning its centre with the ball centre, with the same clamping as a player paddle. It holds if the centres are within PAD_SPD of each other.
- Undefined: the right paddle is player-controlled exactly like the left.

## Test plan
- Reset: assert i_rst for 2 cycles, then drive a visible pixel at (320, 240). Expect RGB 111 (ball) one cycle later, scores 0/0, o_state 0, paddles at 208.
- Serve timer: 60 ticks with no buttons pressed. Expect o_state = 1 after the 60th tick, and ball at (318, 238) after the 61st.
- Top wall: preload ball y = 1 with vy = −2. After one tick expect by = 0 and vy = +2.
- Left paddle hit: pyl = 208, ball at (26, 230), vx = −2. After one tick expect bx = 24 and vx = +2; scores unchanged.
- Left miss: same setup as the paddle hit but pyl = 0, run ticks until the ball crosses x = 0. Expect o_score_r = 1, o_state = 0, ball at (316, 236), vx = −2.
- Game over and restart: from score 8 for the left player, one more left point. Expect o_state = 2 and the left paddle drawn 100. Then pulse i_start on a tick cycle: expect scores 0/0 and o_state = 0, with no ball or paddle motion that frame.
